// File: rtl/scaled_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scaled_adder_pkg
// Purpose : Shared helpers for scaled_adder and adder_core. Provides the
//           full-precision sum width and the signed min/max limits of an
//           output word, which are used for saturation.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package scaled_adder_pkg;

  // Widest output word for which the limit helpers return exact values.
  localparam int c_LIMIT_W = 64;

  // Width that holds the sum of two sign-extended operands without overflow.
  function automatic int sum_width(input int a_w, input int b_w);
    return ((a_w > b_w) ? a_w : b_w) + 1;
  endfunction

  // Largest signed value of a w-bit word: 2^(w-1)-1.
  function automatic logic [c_LIMIT_W-1:0] out_max(input int w);
    return (c_LIMIT_W'(1) << (w - 1)) - c_LIMIT_W'(1);
  endfunction

  // Smallest signed value of a w-bit word: -2^(w-1).
  function automatic logic [c_LIMIT_W-1:0] out_min(input int w);
    return ~out_max(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scaled_adder_core.sv
`default_nettype none
// ============================================================================
// Module  : adder_core
// Purpose : Combinational extend / add / arithmetic-shift / wrap-or-saturate.
//           No state; reusable anywhere a scaled sum is needed.
// Ports   : i_a       [A_WIDTH-1:0]   signed operand a
//           i_b       [B_WIDTH-1:0]   signed operand b
//           o_result  [OUT_WIDTH-1:0] signed scaled result
// Revision: 1.0 - initial release
// ============================================================================
module adder_core
  import scaled_adder_pkg::*;
#(
  parameter int A_WIDTH   = 30,
  parameter int B_WIDTH   = 14,
  parameter int OUT_WIDTH = 15,
  parameter int OUT_SCALE = 20,
  parameter bit SATURATE  = 1'b0
) (
  input  logic [A_WIDTH-1:0]   i_a,
  input  logic [B_WIDTH-1:0]   i_b,
  output logic [OUT_WIDTH-1:0] o_result
);

  localparam int SW = sum_width(A_WIDTH, B_WIDTH);

  localparam logic [OUT_WIDTH-1:0] c_OUT_MAX = OUT_WIDTH'(out_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] c_OUT_MIN = OUT_WIDTH'(out_min(OUT_WIDTH));

  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_shifted;

  // SW exceeds both operand widths, so each replication is at least one bit.
  assign w_sum = $signed({{(SW-A_WIDTH){i_a[A_WIDTH-1]}}, i_a})
               + $signed({{(SW-B_WIDTH){i_b[B_WIDTH-1]}}, i_b});

  generate
    if (OUT_SCALE >= SW) begin : g_shift_all
      // Every magnitude bit is shifted out; only the sign fill remains.
      logic w_unused_sum;
      assign w_unused_sum = ^w_sum[SW-2:0];
      assign w_shifted    = {SW{w_sum[SW-1]}};
    end else begin : g_shift
      assign w_shifted = w_sum >>> OUT_SCALE;
    end

    if (OUT_WIDTH >= SW) begin : g_extend
      // Output is wide enough for any sum: plain sign extension.
      assign o_result = {{(OUT_WIDTH-SW+1){w_shifted[SW-1]}}, w_shifted[SW-2:0]};
    end else begin : g_narrow
      if (SATURATE) begin : g_sat
        // The value fits only when every bit from OUT_WIDTH-1 upward is a copy
        // of the sign; otherwise clamp in the direction of the sign.
        logic [SW-OUT_WIDTH:0] w_hi;
        logic                  w_ovf;
        assign w_hi  = w_shifted[SW-1:OUT_WIDTH-1];
        assign w_ovf = !((&w_hi) || (~|w_hi));
        assign o_result = !w_ovf          ? w_shifted[OUT_WIDTH-1:0] :
                          w_shifted[SW-1] ? c_OUT_MIN : c_OUT_MAX;
      end else begin : g_wrap
        logic w_unused_hi;
        assign w_unused_hi = ^w_shifted[SW-1:OUT_WIDTH];
        assign o_result    = w_shifted[OUT_WIDTH-1:0];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/scaled_adder.sv
`default_nettype none
// ============================================================================
// Module  : scaled_adder
// Purpose : Registered fixed-point adder. adder_core computes the scaled sum;
//           this level adds one output register with a valid/ready handshake.
// Ports   : clk        rising-edge clock
//           arst       asynchronous active-high reset
//           a, b       signed operands (A_WIDTH / B_WIDTH)
//           in_valid   a/b valid this cycle
//           in_ready   stage can accept a/b (combinational on out_ready)
//           out        registered signed result (OUT_WIDTH)
//           out_valid  out holds a result
//           out_ready  consumer accepts out
// Revision: 1.0 - initial release
// ============================================================================
module scaled_adder
  import scaled_adder_pkg::*;
#(
  parameter int A_WIDTH   = 30,
  parameter int B_WIDTH   = 14,
  parameter int OUT_WIDTH = 15,
  parameter int OUT_SCALE = 20,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [OUT_WIDTH-1:0] w_result;
  logic                 w_accept;
  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_out_valid;

  adder_core #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SCALE (OUT_SCALE),
    .SATURATE  (SATURATE)
  ) u_core (
    .i_a      (a),
    .i_b      (b),
    .o_result (w_result)
  );

  // The register can take a new value when empty or being drained this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_result;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_scaled_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_scaled_adder
// Purpose : Self-checking bench for scaled_adder: default-parameter instance
//           plus 8-bit wrap and 8-bit saturate instances.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scaled_adder;

  logic clk;
  logic arst;

  // Default-parameter instance
  logic signed [29:0] a;
  logic signed [13:0] b;
  logic               in_valid;
  logic               in_ready;
  logic signed [14:0] out_d;
  logic               out_valid;
  logic               out_ready;

  // 8-bit instances share stimulus
  logic signed [7:0] a8;
  logic signed [7:0] b8;
  logic              v8;
  logic              r8;
  logic              in_ready_w8, in_ready_s8;
  logic signed [7:0] out_w8, out_s8;
  logic              valid_w8, valid_s8;

  int n_checks;
  int n_fail;

  scaled_adder dut (
    .clk(clk), .arst(arst), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .out(out_d), .out_valid(out_valid), .out_ready(out_ready)
  );

  scaled_adder #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .OUT_SCALE(0), .SATURATE(1'b0)) dut_w8 (
    .clk(clk), .arst(arst), .a(a8), .b(b8), .in_valid(v8),
    .in_ready(in_ready_w8), .out(out_w8), .out_valid(valid_w8), .out_ready(r8)
  );

  scaled_adder #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .OUT_SCALE(0), .SATURATE(1'b1)) dut_s8 (
    .clk(clk), .arst(arst), .a(a8), .b(b8), .in_valid(v8),
    .in_ready(in_ready_s8), .out(out_s8), .out_valid(valid_s8), .out_ready(r8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: floor division by 2^20, then reduce mod 2^15 into signed range.
  function automatic longint ref_out(input longint av, input longint bv);
    longint s, q;
    s = av + bv;
    q = s >>> 20;
    q = q & 64'd32767;
    if (q >= 16384) q = q - 32768;
    return q;
  endfunction

  task automatic drive_default(input string tag, input longint av, input longint bv,
                               input longint exp);
    a = 30'(av);
    b = 14'(bv);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check(tag, longint'(out_d), exp);
    check({tag, "_valid"}, longint'(out_valid), 1);
  endtask

  task automatic drive8(input string tag, input longint av, input longint bv,
                        input longint exp_wrap, input longint exp_sat);
    a8 = 8'(av);
    b8 = 8'(bv);
    v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    check({tag, "_wrap"}, longint'(out_w8), exp_wrap);
    check({tag, "_sat"}, longint'(out_s8), exp_sat);
    check({tag, "_valid"}, longint'(valid_w8 && valid_s8), 1);
  endtask

  initial begin
    bit     m_valid;
    longint m_out;
    bit     acc;
    n_checks  = 0;
    n_fail    = 0;
    arst      = 1'b1;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a8        = '0;
    b8        = '0;
    v8        = 1'b0;
    r8        = 1'b1;

    #3;
    check("rst_out", longint'(out_d), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;

    // Default-parameter directed vectors
    drive_default("max_pos", 64'sd536870911, 64'sd8191, 512);
    drive_default("max_neg", -64'sd536870912, -64'sd8192, -513);
    drive_default("neg_one", -64'sd1, 64'sd0, -1);
    check("neg_one_bits", longint'({1'b0, out_d[14:0]}), 32767);
    drive_default("below_one", 64'sd1048575, 64'sd0, 0);
    drive_default("exact_one", 64'sd1048576, 64'sd0, 1);
    drive_default("mixed", 64'sd3145728, -64'sd1, 2);

    // 8-bit wrap / saturate
    drive8("pos_ovf", 127, 1, -128, 127);
    drive8("neg_ovf", -128, -1, 127, -128);
    drive8("in_range", 50, 20, 70, 70);
    drive8("neg_in_range", -100, 28, -72, -72);

    // Backpressure
    @(posedge clk); #1;
    a = 30'sd5242880; b = '0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_first", longint'(out_d), 5);
    out_ready = 1'b0;
    a = 30'sd7340032;
    #1;
    check("bp_in_ready_low", longint'(in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("bp_hold_out", longint'(out_d), 5);
      check("bp_hold_valid", longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", longint'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_new_out", longint'(out_d), 7);
    check("bp_new_valid", longint'(out_valid), 1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_stall_valid", longint'(out_valid), 1);

    // Asynchronous reset mid-cycle
    arst = 1'b1;
    #1;
    check("arst_out", longint'(out_d), 0);
    check("arst_valid", longint'(out_valid), 0);
    check("arst_in_ready", longint'(in_ready), 1);
    #2 arst = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the reference model
    m_valid = 1'b0;
    m_out   = 0;
    for (int i = 0; i < 10000; i++) begin
      a         = 30'($urandom);
      b         = 14'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_in_ready", longint'(in_ready), longint'(!m_valid || out_ready));
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        m_out   = ref_out(longint'(a), longint'(b));
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("rnd_valid", longint'(out_valid), longint'(m_valid));
      if (m_valid) check("rnd_out", longint'(out_d), m_out);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
